// File: rtl/matrix_memory.sv
// Purpose: ROWS x COLS element store with registered reads, range checking and a row-major clear sweep.
// Latency: reads return on readData/readValid one cycle after the request edge; writes land on the request edge.
// Backpressure: none on the port; while busy is high every read, write and start_clear request is dropped.
module matrix_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 10,
    parameter int COLS       = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_Read,
    input  logic                  en_Write,
    input  logic [3:0]            rowAddr,
    input  logic [3:0]            colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    input  logic                  start_clear,
    output logic                  busy,
    output logic                  addr_err
);

    // Compare in 5 bits so ROWS/COLS up to 16 stay representable.
    localparam logic [4:0] ROWS_L   = 5'(ROWS);
    localparam logic [4:0] COLS_L   = 5'(COLS);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Sweep index kept as a row/column pair; walking columns first gives row-major order.
    logic [3:0] clr_row_q;
    logic [3:0] clr_col_q;

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic addr_ok;
    logic is_idle;
    logic take_clear;
    logic port_rd;
    logic port_wr;
    logic sweep_last;

    assign addr_ok    = ({1'b0, rowAddr} < ROWS_L) && ({1'b0, colAddr} < COLS_L);
    assign is_idle    = (state_q == IDLE);
    // A clear request wins over any access presented on the same edge.
    assign take_clear = is_idle && start_clear;
    assign port_rd    = is_idle && !start_clear && en_Read;
    assign port_wr    = is_idle && !start_clear && en_Write;
    assign sweep_last = (clr_row_q == ROW_LAST) && (clr_col_q == COL_LAST);
    assign busy       = (state_q == CLEAR);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter CLEAR on request, leave on the edge that zeroes the final element.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_clear) state_d = CLEAR;
            CLEAR:   if (sweep_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sweep index: load zero on entry, advance once per CLEAR cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_row_q <= '0;
            clr_col_q <= '0;
        end else if (take_clear) begin
            clr_row_q <= '0;
            clr_col_q <= '0;
        end else if (state_q == CLEAR) begin
            if (clr_col_q == COL_LAST) begin
                clr_col_q <= '0;
                clr_row_q <= clr_row_q + 4'd1;
            end else begin
                clr_col_q <= clr_col_q + 4'd1;
            end
        end
    end

    // Read data, read strobe and range-error strobe; out-of-range reads return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readData  <= '0;
            readValid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            readValid <= port_rd;
            addr_err  <= (port_rd || port_wr) && !addr_ok;
            if (port_rd) begin
                readData <= addr_ok ? mem[rowAddr][colAddr] : '0;
            end
        end
    end

    // Storage writes: the sweep owns the array while clearing, otherwise in-range port writes land.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_row_q][clr_col_q] <= '0;
        end else if (port_wr && addr_ok) begin
            mem[rowAddr][colAddr] <= writeData;
        end
    end

endmodule
